// File: rtl/axi_dma_w.sv
// AXI4 write master for a databus burst port: one AW handshake, len+1 W beats,
// then one B response whose status is latched into error.
module axi_dma_w #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ID_W   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic                  ready,
  input  logic [LEN_W-1:0]      len,
  output logic                  error,
  output logic [ID_W-1:0]       m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [LEN_W-1:0]      m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_W-1:0]       m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  typedef enum logic [1:0] {ADDR_HS, DATA, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_error;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_b_hs;
  logic             w_unused;

  assign m_axi_awid    = '0;
  assign m_axi_awsize  = 3'($clog2(DATA_W/8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'h2;
  assign m_axi_awprot  = 3'b010;
  assign m_axi_awqos   = '0;
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = len;
  assign m_axi_wdata   = wdata;
  assign m_axi_wstrb   = wstrb;
  assign error         = r_error;
  assign w_unused      = ^m_axi_bid;

  // Handshake-qualifying outputs are forced low while rst is high, since the
  // state register alone would still let awvalid follow valid in ADDR_HS.
  always_comb begin
    w_state_nx    = r_state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    ready         = 1'b0;
    w_aw_hs       = 1'b0;
    w_w_hs        = 1'b0;
    w_b_hs        = 1'b0;
    if (!rst) begin
      case (r_state)
        ADDR_HS: begin
          m_axi_awvalid = valid;
          if (valid && m_axi_awready) begin
            w_aw_hs    = 1'b1;
            w_state_nx = DATA;
          end
        end
        DATA: begin
          m_axi_wvalid = valid;
          m_axi_wlast  = (r_cnt == r_len);
          ready        = valid & m_axi_wready;
          if (valid && m_axi_wready) begin
            w_w_hs = 1'b1;
            if (r_cnt == r_len) w_state_nx = RESP;
          end
        end
        RESP: begin
          m_axi_bready = 1'b1;
          if (m_axi_bvalid) begin
            w_b_hs     = 1'b1;
            w_state_nx = ADDR_HS;
          end
        end
        default: w_state_nx = ADDR_HS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ADDR_HS;
      r_cnt   <= '0;
      r_len   <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_aw_hs) begin
        r_len <= len;
        r_cnt <= '0;
      end
      if (w_w_hs) r_cnt <= r_cnt + 1'b1;
      if (w_b_hs) r_error <= (m_axi_bresp != 2'b00);
    end
  end

endmodule
